// File: rtl/prog_tick_timer_pkg.sv
// Shared definitions for the programmable tick timer.
//   mode_e           : channel mode encoding (periodic / one-shot)
//   DEFAULT_PRESCALE : system clocks per base strobe (1 ms at 50 MHz)
//   clog2w()         : counter width for a modulus, never below 1 bit
package timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_PRESCALE = 50000;

    function automatic int unsigned clog2w(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/prog_tick_timer_if.sv
// Control/status bundle of the tick timer.
//   en, mode, load, div_in : per-channel controls (driven by master)
//   tick, busy, base_tick  : timer outputs (driven by slave = timer)
interface prog_tick_timer_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 12
);
    logic [NCH-1:0] en;
    logic [NCH-1:0] mode;
    logic [NCH-1:0] load;
    logic [CW-1:0]  div_in;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic           base_tick;

    modport master (
        output en, mode, load, div_in,
        input  tick, busy, base_tick
    );

    modport slave (
        input  en, mode, load, div_in,
        output tick, busy, base_tick
    );
endinterface

// File: rtl/prog_tick_timer_tick_channel.sv
// One timer channel: divides the base strobe by a loadable divisor.
//   clk, rst : clock, async active-high reset
//   s        : base strobe (one clk wide)
//   en       : run enable, low holds the count
//   mode     : 0 periodic, 1 one-shot
//   load     : load div_in, clear count, re-arm
//   div_in   : new divisor
//   tick     : registered one-cycle pulse on terminal count
//   busy     : channel is counting toward a tick
module tick_channel
    import timer_pkg::*;
#(
    parameter int unsigned CW          = 12,
    parameter int unsigned DEFAULT_DIV = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s,
    input  logic          en,
    input  logic          mode,
    input  logic          load,
    input  logic [CW-1:0] div_in,
    output logic          tick,
    output logic          busy
);

    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          tick_q, tick_d;
    logic          active;
    mode_e         mode_s;

    assign mode_s = mode_e'(mode);
    assign active = (div_q != '0) && ((mode_s == MODE_PERIODIC) || armed_q);

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        tick_d  = 1'b0;
        // Load outranks the strobe, so a coinciding terminal count is dropped.
        if (load) begin
            div_d   = div_in;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (en && s && active) begin
            if (cnt_q == div_q - CW'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (mode_s == MODE_ONESHOT) begin
                    armed_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= CW'(DEFAULT_DIV);
            cnt_q   <= '0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
    // Reset state alone would leave a periodic channel busy, so rst masks it.
    assign busy = !rst && en && active;

endmodule

// File: rtl/prog_tick_timer.sv
// Multi-channel programmable tick generator.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of prog_tick_timer_if
//              (en/mode/load/div_in in, tick/busy/base_tick out)
// A free-running prescaler produces the base strobe shared by NCH channels.
module prog_tick_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE    = DEFAULT_PRESCALE,
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 12,
    parameter int unsigned DEFAULT_DIV = 100
) (
    input  logic           clk,
    input  logic           rst,
    prog_tick_timer_if.slave bus
);

    localparam int unsigned PW = clog2w(PRESCALE);

    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           base_tick_q, base_tick_d;
    logic           s;
    logic [NCH-1:0] tick_w;
    logic [NCH-1:0] busy_w;

    always_comb begin
        s           = (pcnt_q == PW'(PRESCALE - 1));
        pcnt_d      = s ? '0 : pcnt_q + PW'(1);
        base_tick_d = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q      <= '0;
            base_tick_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            base_tick_q <= base_tick_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .s      (s),
            .en     (bus.en[i]),
            .mode   (bus.mode[i]),
            .load   (bus.load[i]),
            .div_in (bus.div_in),
            .tick   (tick_w[i]),
            .busy   (busy_w[i])
        );
    end

    assign bus.tick      = tick_w;
    assign bus.busy      = busy_w;
    assign bus.base_tick = base_tick_q;

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed bench for prog_tick_timer with PRESCALE=4, CW=8.
// ec counts clock edges since the last reset release; base strobes are
// consumed on edges that are multiples of 4, so every hand-computed tick
// edge below is a multiple of 4.
module tb_prog_tick_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ec;
    int   total = 0;
    int   bad   = 0;

    prog_tick_timer_if #(.NCH(2), .CW(8)) bus2 ();
    prog_tick_timer_if #(.NCH(4), .CW(8)) bus4 ();

    prog_tick_timer #(
        .PRESCALE (4), .NCH (2), .CW (8), .DEFAULT_DIV (100)
    ) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    prog_tick_timer #(
        .PRESCALE (4), .NCH (4), .CW (8), .DEFAULT_DIV (100)
    ) u_dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    task automatic go_to(input int e);
        while (ec < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus2.en = '0; bus2.mode = '0; bus2.load = '0; bus2.div_in = '0;
        bus4.en = '0; bus4.mode = '0; bus4.load = '0; bus4.div_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        bus2.en = 2'b11; bus2.load = 2'b10; bus2.div_in = 8'd2;
        go_to(1);
        bus2.load = 2'b01; bus2.div_in = 8'd3;
        go_to(2);
        bus2.load = 2'b00;
        go_to(8);
        // ch1 (div 2) fires on strobe 8, ch0 (div 3) sits at cnt=2
        total++; if (bus2.base_tick !== 1'b1) begin bad++; $display("FAIL pre_rst_base got=%0b exp=1", bus2.base_tick); end
        total++; if (bus2.tick !== 2'b10) begin bad++; $display("FAIL pre_rst_tick got=%b exp=10", bus2.tick); end
        total++; if (bus2.busy !== 2'b11) begin bad++; $display("FAIL pre_rst_busy got=%b exp=11", bus2.busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus2.base_tick !== 1'b0) begin bad++; $display("FAIL async_rst_base got=%0b exp=0", bus2.base_tick); end
        total++; if (bus2.tick !== 2'b00) begin bad++; $display("FAIL async_rst_tick got=%b exp=00", bus2.tick); end
        total++; if (bus2.busy !== 2'b00) begin bad++; $display("FAIL async_rst_busy got=%b exp=00", bus2.busy); end
        bus2.en = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            go_to(e);
            total++;
            if (bus2.base_tick !== ((e % 4) == 0)) begin
                bad++; $display("FAIL base_tick e=%0d got=%0b exp=%0b", e, bus2.base_tick, (e % 4) == 0);
            end
        end
    endtask

    task automatic test_periodic();
        do_reset();
        bus2.en = 2'b01; bus2.mode = 2'b00; bus2.load = 2'b01; bus2.div_in = 8'd3;
        for (int e = 1; e <= 40; e++) begin
            go_to(e);
            if (e == 1) bus2.load = 2'b00;
            total++;
            if (bus2.tick !== {1'b0, (e % 12) == 0}) begin
                bad++; $display("FAIL periodic_tick e=%0d got=%b exp=%b", e, bus2.tick, {1'b0, (e % 12) == 0});
            end
            total++;
            if (bus2.busy[0] !== 1'b1) begin
                bad++; $display("FAIL periodic_busy e=%0d got=%0b exp=1", e, bus2.busy[0]);
            end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        bus2.en = 2'b10; bus2.mode = 2'b10; bus2.load = 2'b10; bus2.div_in = 8'd2;
        for (int e = 1; e <= 64; e++) begin
            go_to(e);
            if (e == 1 || e == 49) bus2.load = 2'b00;
            total++;
            if (bus2.tick[1] !== (e == 8 || e == 56)) begin
                bad++; $display("FAIL oneshot_tick e=%0d got=%0b exp=%0b", e, bus2.tick[1], e == 8 || e == 56);
            end
            total++;
            if (bus2.busy[1] !== (e < 8 || (e > 48 && e < 56))) begin
                bad++; $display("FAIL oneshot_busy e=%0d got=%0b exp=%0b", e, bus2.busy[1], e < 8 || (e > 48 && e < 56));
            end
            if (e == 48) begin
                bus2.load = 2'b10; bus2.div_in = 8'd2;
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        bus2.en = 2'b01; bus2.mode = 2'b00; bus2.load = 2'b01; bus2.div_in = 8'd5;
        for (int e = 1; e <= 64; e++) begin
            go_to(e);
            if (e == 1) bus2.load = 2'b00;
            total++;
            if (bus2.tick[0] !== (e == 60)) begin
                bad++; $display("FAIL pause_tick e=%0d got=%0b exp=%0b", e, bus2.tick[0], e == 60);
            end
            total++;
            if (bus2.busy[0] !== (e <= 8 || e > 48)) begin
                bad++; $display("FAIL pause_busy e=%0d got=%0b exp=%0b", e, bus2.busy[0], e <= 8 || e > 48);
            end
            if (e == 8)  bus2.en = 2'b00;
            if (e == 48) bus2.en = 2'b01;
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus2.en = 2'b01; bus2.mode = 2'b00; bus2.load = 2'b01; bus2.div_in = 8'd3;
        for (int e = 1; e <= 40; e++) begin
            go_to(e);
            if (e == 1 || e == 12) bus2.load = 2'b00;
            total++;
            if (bus2.tick[0] !== (e == 36)) begin
                bad++; $display("FAIL collision_tick e=%0d got=%0b exp=%0b", e, bus2.tick[0], e == 36);
            end
            if (e == 11) begin
                bus2.load = 2'b01; bus2.div_in = 8'd6;
            end
        end
    endtask

    task automatic test_div_edges();
        do_reset();
        bus2.en = 2'b01; bus2.mode = 2'b00; bus2.load = 2'b01; bus2.div_in = 8'd0;
        for (int e = 1; e <= 50; e++) begin
            go_to(e);
            if (e == 1) bus2.load = 2'b00;
            total++;
            if (bus2.tick[0] !== 1'b0 || bus2.busy[0] !== 1'b0) begin
                bad++; $display("FAIL div0 e=%0d tick=%0b busy=%0b exp=0/0", e, bus2.tick[0], bus2.busy[0]);
            end
        end
        bus2.load = 2'b01; bus2.div_in = 8'd1;
        for (int e = 51; e <= 68; e++) begin
            go_to(e);
            if (e == 51) bus2.load = 2'b00;
            total++;
            if (bus2.tick[0] !== ((e % 4) == 0)) begin
                bad++; $display("FAIL div1_tick e=%0d got=%0b exp=%0b", e, bus2.tick[0], (e % 4) == 0);
            end
            total++;
            if (bus2.busy[0] !== 1'b1) begin
                bad++; $display("FAIL div1_busy e=%0d got=%0b exp=1", e, bus2.busy[0]);
            end
        end
    endtask

    task automatic test_four_channels();
        logic [3:0] exp;
        do_reset();
        // Loads on edges 1,2,3,5 avoid the strobe edge 4; en is raised after edge 5.
        bus4.load = 4'b0001; bus4.div_in = 8'd1;
        go_to(1); bus4.load = 4'b0010; bus4.div_in = 8'd2;
        go_to(2); bus4.load = 4'b0100; bus4.div_in = 8'd3;
        go_to(3); bus4.load = 4'b0000;
        go_to(4); bus4.load = 4'b1000; bus4.div_in = 8'd4;
        go_to(5); bus4.load = 4'b0000; bus4.en = 4'b1111;
        for (int e = 6; e <= 60; e++) begin
            go_to(e);
            exp[0] = (e >= 8)  && ((e % 4) == 0);
            exp[1] = (e >= 12) && (((e - 12) % 8) == 0);
            exp[2] = (e >= 16) && (((e - 16) % 12) == 0);
            exp[3] = (e >= 20) && (((e - 20) % 16) == 0);
            total++;
            if (bus4.tick !== exp) begin
                bad++; $display("FAIL nch4_tick e=%0d got=%b exp=%b", e, bus4.tick, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_mid_count();
        test_periodic();
        test_oneshot();
        test_pause();
        test_collision();
        test_div_edges();
        test_four_channels();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
